// File: rtl/rom_loader_pkg.sv
// Shared types and widths for the flash-to-SRAM boot copier.
// ROM_LOADER_VERIFY_EN adds a read-back verify state.
package rom_loader_pkg;

  localparam int FL_AW   = 23;
  localparam int SRAM_AW = 20;
  localparam int SRAM_DW = 16;

  typedef enum logic [3:0] {
    S_IDLE,
    S_RD_LO,
    S_RD_HI,
    S_WR_SETUP,
    S_WR_PULSE,
    S_WR_HOLD,
`ifdef ROM_LOADER_VERIFY_EN
    S_VRF,
`endif
    S_NEXT,
    S_DONE
  } state_e;

endpackage

// File: rtl/rom_loader_if.sv
// Asynchronous SRAM bus driven by the boot copier.
// Member names follow the copier's pin names.
interface rom_loader_if;
  import rom_loader_pkg::*;

  logic [SRAM_AW-1:0] o_sram_addr;
  logic [SRAM_DW-1:0] o_sram_wdata;
  logic [SRAM_DW-1:0] i_sram_rdata;
  logic               o_sram_oe_n;
  logic               o_sram_we_n;
  logic               o_sram_ub_n;
  logic               o_sram_lb_n;

  modport master (
    output o_sram_addr,
    output o_sram_wdata,
    input  i_sram_rdata,
    output o_sram_oe_n,
    output o_sram_we_n,
    output o_sram_ub_n,
    output o_sram_lb_n
  );

  modport slave (
    input  o_sram_addr,
    input  o_sram_wdata,
    output i_sram_rdata,
    input  o_sram_oe_n,
    input  o_sram_we_n,
    input  o_sram_ub_n,
    input  o_sram_lb_n
  );

endinterface

// File: rtl/rom_loader_sram_wr.sv
// SRAM strobe sequencer: registered strobes decoded from next state.
// ROM_LOADER_VERIFY_EN adds read-back compare and sticky o_err.
module rom_loader_sram_wr
  import rom_loader_pkg::*;
(
  input  logic               i_clk,
  input  logic               i_rst,
  input  state_e             i_state_d,
  input  logic               i_load,
  input  logic [SRAM_AW-1:0] i_addr,
  input  logic [SRAM_DW-1:0] i_wdata,
  rom_loader_if.master       sram
`ifdef ROM_LOADER_VERIFY_EN
  ,
  input  logic               i_clr,
  input  logic               i_cmp,
  output logic               o_err
`endif
);

  logic [SRAM_AW-1:0] addr_q, addr_d;
  logic [SRAM_DW-1:0] wdata_q, wdata_d;
  logic               we_n_q, we_n_d;
  logic               bs_n_q, bs_n_d;

  always_comb begin
    addr_d  = addr_q;
    wdata_d = wdata_q;
    if (i_load) begin
      addr_d  = i_addr;
      wdata_d = i_wdata;
    end
    we_n_d = (i_state_d != S_WR_PULSE);
    bs_n_d = !(i_state_d inside {
      S_WR_SETUP, S_WR_PULSE, S_WR_HOLD
`ifdef ROM_LOADER_VERIFY_EN
      , S_VRF
`endif
    });
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      addr_q  <= '0;
      wdata_q <= '0;
      we_n_q  <= 1'b1;
      bs_n_q  <= 1'b1;
    end else begin
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      we_n_q  <= we_n_d;
      bs_n_q  <= bs_n_d;
    end
  end

  assign sram.o_sram_addr  = addr_q;
  assign sram.o_sram_wdata = wdata_q;
  assign sram.o_sram_we_n  = we_n_q;
  assign sram.o_sram_ub_n  = bs_n_q;
  assign sram.o_sram_lb_n  = bs_n_q;

`ifdef ROM_LOADER_VERIFY_EN
  logic oe_n_q, oe_n_d;
  logic err_q, err_d;

  always_comb begin
    oe_n_d = (i_state_d != S_VRF);
    err_d  = err_q;
    if (i_clr) err_d = 1'b0;
    if (i_cmp && (sram.i_sram_rdata != wdata_q))
      err_d = 1'b1;
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      oe_n_q <= 1'b1;
      err_q  <= 1'b0;
    end else begin
      oe_n_q <= oe_n_d;
      err_q  <= err_d;
    end
  end

  assign sram.o_sram_oe_n = oe_n_q;
  assign o_err            = err_q;
`else
  assign sram.o_sram_oe_n = 1'b1;
`endif

endmodule

// File: rtl/rom_loader.sv
// Boot copier: moves byte-wide flash regions into 16-bit SRAM.
// ROM_LOADER_VERIFY_EN enables read-back verify and o_err.
module rom_loader
  import rom_loader_pkg::*;
#(
  parameter int NUM_REGIONS = 2,
  parameter int FL_LAT      = 2,
  parameter int WE_CYC      = 2,
  parameter int LEN_W       = 16,
  localparam int RW = (NUM_REGIONS > 1) ? $clog2(NUM_REGIONS) : 1
) (
  input  logic                                i_clk,
  input  logic                                i_rst,
  input  logic                                i_start,
  input  logic [NUM_REGIONS-1:0][FL_AW-1:0]   i_src_base,
  input  logic [NUM_REGIONS-1:0][SRAM_AW-1:0] i_dst_base,
  input  logic [NUM_REGIONS-1:0][LEN_W-1:0]   i_len_words,
  output logic                                o_busy,
  output logic                                o_done,
  output logic [RW-1:0]                       o_region,
  output logic [FL_AW-1:0]                    o_fl_addr,
  input  logic [7:0]                          i_fl_rdata,
  rom_loader_if.master                        sram
`ifdef ROM_LOADER_VERIFY_EN
  ,
  output logic                                o_err
`endif
);

  localparam int CMAX = (FL_LAT > WE_CYC) ? FL_LAT : WE_CYC;
  localparam int CW   = (CMAX > 1) ? $clog2(CMAX + 1) : 1;

  state_e state_q, state_d;

  logic [NUM_REGIONS-1:0][FL_AW-1:0]   src_q, src_d;
  logic [NUM_REGIONS-1:0][SRAM_AW-1:0] dst_q, dst_d;
  logic [NUM_REGIONS-1:0][LEN_W-1:0]   len_q, len_d;
  logic [RW-1:0]    reg_q, reg_d;
  logic [LEN_W-1:0] k_q, k_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [7:0]       lo_q, lo_d;
  logic             done_q, done_d;

  logic             start_acc;
  logic [LEN_W:0]   k_inc;
  logic             more_words;
  logic             nxt_found;
  logic [RW-1:0]    nxt_idx;
  logic             rd_last, pulse_last;
  logic [FL_AW-1:0] fl_base;
  logic             wr_load;
  logic [SRAM_AW-1:0] wr_addr;

  assign start_acc  = i_start &&
                      (state_q == S_IDLE || state_q == S_DONE);
  assign k_inc      = {1'b0, k_q} + {{LEN_W{1'b0}}, 1'b1};
  assign more_words = k_inc < {1'b0, len_q[reg_q]};
  assign rd_last    = cnt_q == CW'(FL_LAT);
  assign pulse_last = cnt_q == CW'(WE_CYC - 1);

  // Lowest-numbered later region with a nonzero word count.
  always_comb begin
    nxt_found = 1'b0;
    nxt_idx   = '0;
    for (int i = NUM_REGIONS - 1; i >= 0; i--) begin
      if (RW'(i) > reg_q && len_q[i] != '0) begin
        nxt_found = 1'b1;
        nxt_idx   = RW'(i);
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE, S_DONE: begin
        state_d = S_IDLE;
        if (start_acc)
          state_d = (i_len_words[0] != '0) ? S_RD_LO : S_NEXT;
      end
      S_RD_LO:    if (rd_last) state_d = S_RD_HI;
      S_RD_HI:    if (rd_last) state_d = S_WR_SETUP;
      S_WR_SETUP: state_d = S_WR_PULSE;
      S_WR_PULSE: if (pulse_last) state_d = S_WR_HOLD;
`ifdef ROM_LOADER_VERIFY_EN
      S_WR_HOLD:  state_d = S_VRF;
      S_VRF:
        if (cnt_q == CW'(1))
          state_d = more_words ? S_RD_LO : S_NEXT;
`else
      S_WR_HOLD:  state_d = more_words ? S_RD_LO : S_NEXT;
`endif
      S_NEXT:
        state_d = (more_words || nxt_found) ? S_RD_LO : S_DONE;
      default:    state_d = S_IDLE;
    endcase
  end

  always_comb begin
    o_busy   = !(state_q == S_IDLE || state_q == S_DONE);
    o_done   = done_q;
    o_region = reg_q;
    fl_base  = src_q[reg_q] + FL_AW'({k_q, 1'b0});
    unique case (state_q)
      S_RD_LO: o_fl_addr = fl_base;
      S_RD_HI: o_fl_addr = fl_base + FL_AW'(1);
      default: o_fl_addr = '0;
    endcase
    wr_load = (state_q == S_RD_HI) && (state_d == S_WR_SETUP);
    wr_addr = dst_q[reg_q] + SRAM_AW'(k_q);
  end

  always_comb begin
    src_d  = src_q;
    dst_d  = dst_q;
    len_d  = len_q;
    reg_d  = reg_q;
    k_d    = k_q;
    lo_d   = lo_q;
    done_d = done_q;
    cnt_d  = (state_d == state_q) ? cnt_q + CW'(1) : '0;
    if (start_acc) begin
      src_d  = i_src_base;
      dst_d  = i_dst_base;
      len_d  = i_len_words;
      reg_d  = '0;
      k_d    = '0;
      done_d = 1'b0;
    end else if (state_d == S_RD_LO && state_q != S_RD_LO) begin
      if (more_words) begin
        k_d = k_inc[LEN_W-1:0];
      end else begin
        k_d   = '0;
        reg_d = nxt_idx;
      end
    end
    if (state_q == S_RD_LO && rd_last) lo_d = i_fl_rdata;
    if (state_d == S_DONE) done_d = 1'b1;
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      src_q  <= '0;
      dst_q  <= '0;
      len_q  <= '0;
      reg_q  <= '0;
      k_q    <= '0;
      cnt_q  <= '0;
      lo_q   <= '0;
      done_q <= 1'b0;
    end else begin
      src_q  <= src_d;
      dst_q  <= dst_d;
      len_q  <= len_d;
      reg_q  <= reg_d;
      k_q    <= k_d;
      cnt_q  <= cnt_d;
      lo_q   <= lo_d;
      done_q <= done_d;
    end
  end

  rom_loader_sram_wr u_sram_wr (
    .i_clk     (i_clk),
    .i_rst     (i_rst),
    .i_state_d (state_d),
    .i_load    (wr_load),
    .i_addr    (wr_addr),
    .i_wdata   ({i_fl_rdata, lo_q}),
    .sram      (sram)
`ifdef ROM_LOADER_VERIFY_EN
    ,
    .i_clr     (start_acc),
    .i_cmp     (state_q == S_VRF && cnt_q == CW'(1)),
    .o_err     (o_err)
`endif
  );

endmodule

// File: tb/tb_rom_loader.sv
// Scoreboard bench for rom_loader: directed copy runs, reset, wrap.
// Build with ROM_LOADER_VERIFY_EN to exercise read-back verify.
module tb_rom_loader;
  import rom_loader_pkg::*;

  localparam int NR     = 2;
  localparam int FL_LAT = 2;
  localparam int WE_CYC = 2;
  localparam int LEN_W  = 16;
`ifdef ROM_LOADER_VERIFY_EN
  localparam int WL = 12;
`else
  localparam int WL = 10;
`endif

  logic clk = 1'b0;
  logic rst, start;
  logic [NR-1:0][FL_AW-1:0]   src;
  logic [NR-1:0][SRAM_AW-1:0] dst;
  logic [NR-1:0][LEN_W-1:0]   len;
  logic busy, done;
  logic [0:0] region;
  logic [FL_AW-1:0] fl_addr;
  logic [7:0] fl_rdata;
`ifdef ROM_LOADER_VERIFY_EN
  logic err;
`endif

  rom_loader_if sif ();

  rom_loader #(
    .NUM_REGIONS (NR),
    .FL_LAT      (FL_LAT),
    .WE_CYC      (WE_CYC),
    .LEN_W       (LEN_W)
  ) dut (
    .i_clk       (clk),
    .i_rst       (rst),
    .i_start     (start),
    .i_src_base  (src),
    .i_dst_base  (dst),
    .i_len_words (len),
    .o_busy      (busy),
    .o_done      (done),
    .o_region    (region),
    .o_fl_addr   (fl_addr),
    .i_fl_rdata  (fl_rdata),
    .sram        (sif)
`ifdef ROM_LOADER_VERIFY_EN
    ,
    .o_err       (err)
`endif
  );

  always #5 clk = ~clk;

  function automatic logic [7:0] fl_byte(input logic [22:0] a);
    return a[7:0] ^ a[15:8] ^ {1'b0, a[22:16]};
  endfunction

  // Flash model: data valid FL_LAT cycles after the address
  logic [FL_AW-1:0] apipe [FL_LAT];
  always @(posedge clk) begin
    apipe[0] <= fl_addr;
    for (int i = 1; i < FL_LAT; i++) apipe[i] <= apipe[i-1];
  end
  assign fl_rdata = fl_byte(apipe[FL_LAT-1]);

  logic [15:0] smem [16];
  logic corrupt;
  assign sif.i_sram_rdata = sif.o_sram_oe_n ? 16'h0 :
    (smem[sif.o_sram_addr[3:0]] ^
     ((corrupt && sif.o_sram_addr == 20'h2) ? 16'h0040 : 16'h0));

  typedef struct packed {
    logic [0:0]  rg;
    logic [19:0] a;
    logic [15:0] d;
  } wr_t;
  wr_t exp_q[$];

  int n_tests = 0;
  int n_fail  = 0;
  int n_writes = 0;
  logic watch_en = 1'b0;
  logic bad_seen = 1'b0;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] expv);
    n_tests++;
    if (act !== expv) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h required 0x%0h", nm, act, expv);
    end
  endtask

  task automatic push(input logic [0:0] rg, input logic [19:0] a,
                      input logic [15:0] d);
    wr_t e;
    e.rg = rg; e.a = a; e.d = d;
    exp_q.push_back(e);
  endtask

  // Monitor: one scoreboard pop per completed we_n pulse
  initial begin
    int width;
    logic prev_we;
    logic strobe_ok;
    wr_t e;
    width = 0; prev_we = 1'b1; strobe_ok = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      if (watch_en && fl_addr[22:1] == 22'h280) bad_seen = 1'b1;
      if (rst) begin
        width = 0; prev_we = 1'b1; strobe_ok = 1'b1;
      end else begin
        if (!sif.o_sram_we_n) begin
          width++;
          if (sif.o_sram_ub_n || sif.o_sram_lb_n || !sif.o_sram_oe_n)
            strobe_ok = 1'b0;
        end else if (!prev_we) begin
          n_writes++;
          smem[sif.o_sram_addr[3:0]] = sif.o_sram_wdata;
          if (exp_q.size() == 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL unexpected_write: got addr 0x%0h data 0x%0h required none",
                     sif.o_sram_addr, sif.o_sram_wdata);
          end else begin
            e = exp_q.pop_front();
            chk("wr_addr", 32'(sif.o_sram_addr), 32'(e.a));
            chk("wr_data", 32'(sif.o_sram_wdata), 32'(e.d));
            chk("wr_region", 32'(region), 32'(e.rg));
            chk("we_width", width, WE_CYC);
            chk("wr_strobes", 32'(strobe_ok), 1);
          end
          width = 0;
          strobe_ok = 1'b1;
        end
        prev_we = sif.o_sram_we_n;
      end
    end
  end

  task automatic set_tbl(input logic [22:0] s0, input logic [19:0] d0,
                         input logic [15:0] l0, input logic [22:0] s1,
                         input logic [19:0] d1, input logic [15:0] l1);
    src[0] = s0; dst[0] = d0; len[0] = l0;
    src[1] = s1; dst[1] = d1; len[1] = l1;
  endtask

  task automatic push_t1();
    push(1'b0, 20'h0, 16'h0100);
    push(1'b0, 20'h1, 16'h0302);
    push(1'b0, 20'h2, 16'h0504);
    push(1'b0, 20'h3, 16'h0706);
  endtask

  task automatic go_and_wait(input string nm, input int exp_lat,
                             input int poke_at, input logic exp_err);
    int lat;
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk({nm, "_busy"}, 32'(busy), 1);
`ifdef ROM_LOADER_VERIFY_EN
    chk({nm, "_err_clr"}, 32'(err), 0);
`endif
    lat = 0;
    while (!done && lat < 2000) begin
      @(negedge clk);
      lat++;
      start = (lat == poke_at);
      if (lat == poke_at) set_tbl(23'h123456, 20'h55, 16'h9, 23'h7, 20'h9, 16'h3);
    end
    start = 1'b0;
    chk({nm, "_lat"}, lat, exp_lat);
    chk({nm, "_idle"}, 32'(busy), 0);
    repeat (3) @(negedge clk);
    chk({nm, "_done_held"}, 32'(done), 1);
    chk({nm, "_left"}, exp_q.size(), 0);
`ifdef ROM_LOADER_VERIFY_EN
    chk({nm, "_err"}, 32'(err), 32'(exp_err));
`else
    if (exp_err) $display("note: %s expects verify error", nm);
`endif
  endtask

  initial begin
    int lat;
    int w0;
    rst = 1'b1;
    start = 1'b0;
    corrupt = 1'b0;
    set_tbl('0, '0, '0, '0, '0, '0);
    for (int i = 0; i < 16; i++) smem[i] = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_done", 32'(done), 0);
    chk("rst_region", 32'(region), 0);
    chk("rst_fl_addr", 32'(fl_addr), 0);
    chk("rst_we_n", 32'(sif.o_sram_we_n), 1);
    chk("rst_oe_n", 32'(sif.o_sram_oe_n), 1);
    chk("rst_ub_lb", 32'({sif.o_sram_ub_n, sif.o_sram_lb_n}), 3);
    chk("rst_addr", 32'(sif.o_sram_addr), 0);
    rst = 1'b0;

    // single region, flash[n] = n
    set_tbl(23'h0, 20'h0, 16'd4, 23'h0, 20'h0, 16'd0);
    push_t1();
    go_and_wait("t1", 4 * WL + 1, -1, 1'b0);

    // start pulse mid-run with a scrambled table is ignored
    set_tbl(23'h0, 20'h0, 16'd4, 23'h0, 20'h0, 16'd0);
    push_t1();
    go_and_wait("midstart", 4 * WL + 1, 15, 1'b0);

    // two regions
    set_tbl(23'h10, 20'h800, 16'd2, 23'h4000, 20'h0, 16'd1);
    push(1'b0, 20'h800, 16'h1110);
    push(1'b0, 20'h801, 16'h1312);
    push(1'b1, 20'h000, 16'h4140);
    w0 = n_writes;
    go_and_wait("t2", 3 * WL + 2, -1, 1'b0);
    chk("t2_writes", n_writes - w0, 3);

    // zero-length first region
    set_tbl(23'h500, 20'h400, 16'd0, 23'h20, 20'h123, 16'd1);
    push(1'b1, 20'h123, 16'h2120);
    bad_seen = 1'b0;
    watch_en = 1'b1;
    go_and_wait("t3", WL + 2, -1, 1'b0);
    watch_en = 1'b0;
    chk("t3_no_flash", 32'(bad_seen), 0);

    // all-zero table
    set_tbl(23'h10, 20'h10, 16'd0, 23'h20, 20'h20, 16'd0);
    go_and_wait("zero", 1, -1, 1'b0);

    // address wrap on both buses
    set_tbl(23'h7FFFFE, 20'hFFFFF, 16'd2, 23'h0, 20'h0, 16'd0);
    push(1'b0, 20'hFFFFF, 16'h7F7E);
    push(1'b0, 20'h00000, 16'h0100);
    go_and_wait("wrap", 2 * WL + 1, -1, 1'b0);

    // reset during the we_n pulse of word 2, then restart
    set_tbl(23'h0, 20'h0, 16'd4, 23'h0, 20'h0, 16'd0);
    push(1'b0, 20'h0, 16'h0100);
    push(1'b0, 20'h1, 16'h0302);
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    lat = 0;
    while (!(!sif.o_sram_we_n && sif.o_sram_addr == 20'h2) && lat < 500) begin
      @(negedge clk);
      lat++;
    end
    chk("rmid_reach", 32'(lat < 500), 1);
    rst = 1'b1;
    @(posedge clk);
    #1;
    chk("rmid_we_n", 32'(sif.o_sram_we_n), 1);
    chk("rmid_busy", 32'(busy), 0);
    chk("rmid_done", 32'(done), 0);
    chk("rmid_region", 32'(region), 0);
    chk("rmid_fl_addr", 32'(fl_addr), 0);
    chk("rmid_addr", 32'(sif.o_sram_addr), 0);
    chk("rmid_wdata", 32'(sif.o_sram_wdata), 0);
    chk("rmid_strb", 32'({sif.o_sram_ub_n, sif.o_sram_lb_n, sif.o_sram_oe_n}), 7);
    @(negedge clk);
    rst = 1'b0;
    chk("rmid_left", exp_q.size(), 0);
    push_t1();
    go_and_wait("restart", 4 * WL + 1, -1, 1'b0);

`ifdef ROM_LOADER_VERIFY_EN
    // read-back of word 2 corrupted by the SRAM model
    corrupt = 1'b1;
    push_t1();
    go_and_wait("vrf_bad", 4 * WL + 1, -1, 1'b1);
    corrupt = 1'b0;
    push_t1();
    go_and_wait("vrf_ok", 4 * WL + 1, -1, 1'b0);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
